// File: rtl/light_stim_drv.sv
//==============================================================================
// Module      : light_stim_drv
// Description : Stimulus driver for the light-game FSM. Conditions the player
//               key into L pulses, opens pseudo-random M windows from an LFSR,
//               sequences rounds and keeps a saturating win score.
//               Optional round timeout: define LIGHT_STIM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module light_stim_drv #(
  parameter int          WINDOW    = 4,
  parameter int          RATE_BITS = 3,
  parameter int          WIN_HOLD  = 8,
  parameter int          SCORE_W   = 4,
  parameter logic [15:0] SEED      = 16'hACE1
`ifdef LIGHT_STIM_TIMEOUT_EN
  ,
  parameter int          TIMEOUT   = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic               start,
  input  logic               stop,
  input  logic               W,
  output logic               M,
  output logic               L,
  output logic               game_rst,
  output logic [SCORE_W-1:0] score,
  output logic               active
`ifdef LIGHT_STIM_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ARM    = 2'd1;
  localparam logic [1:0] c_ACTIVE = 2'd2;
  localparam logic [1:0] c_HOLD   = 2'd3;

  localparam int                c_WIN_W   = $clog2(WINDOW + 1);
  localparam int                c_HOLD_W  = $clog2(WIN_HOLD + 1);
  localparam logic [c_WIN_W-1:0]  c_WINDOW  = c_WIN_W'(WINDOW);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LD = c_HOLD_W'(WIN_HOLD - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                w_win_hit;
  logic [15:0]         r_lfsr;
  logic                w_fb;
  logic [c_WIN_W-1:0]  r_win_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [SCORE_W-1:0]  r_score;
  logic                r_key_s1;
  logic                r_key_s2;
  logic                r_key_s3;
  logic                r_l;
  logic                w_stay_active;

`ifdef LIGHT_STIM_TIMEOUT_EN
  localparam int               c_TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_TO_W-1:0] c_TO_HIT = c_TO_W'(TIMEOUT - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_timeout;
  logic              w_to_hit;

  assign w_to_hit = (r_state == c_ACTIVE) && (r_to_cnt == c_TO_HIT);
  assign timeout  = r_timeout;
`endif

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_comb begin
    w_state_nxt = r_state;
    w_win_hit   = 1'b0;
    if (stop) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:   if (start) w_state_nxt = c_ARM;
        c_ARM:    w_state_nxt = c_ACTIVE;
        c_ACTIVE: begin
          if (W) begin
            w_win_hit   = 1'b1;
            w_state_nxt = c_HOLD;
          end
`ifdef LIGHT_STIM_TIMEOUT_EN
          else if (w_to_hit) begin
            w_state_nxt = c_ARM;
          end
`endif
        end
        c_HOLD:   if (r_hold_cnt == '0) w_state_nxt = c_ARM;
        default:  w_state_nxt = c_IDLE;
      endcase
    end
  end

  // Window and L activity require ACTIVE both now and next cycle, so both drop
  // together with the state leaving ACTIVE and nothing leaks into ARM/HOLD.
  assign w_stay_active = (r_state == c_ACTIVE) && (w_state_nxt == c_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_lfsr     <= SEED;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_score    <= '0;
      r_key_s1   <= 1'b0;
      r_key_s2   <= 1'b0;
      r_key_s3   <= 1'b0;
      r_l        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      r_key_s3 <= r_key_s2;
      r_l      <= r_key_s2 && !r_key_s3 && w_stay_active;

      if (r_state == c_ACTIVE) begin
        r_lfsr <= {w_fb, r_lfsr[15:1]};
      end

      if (!w_stay_active) begin
        r_win_cnt <= '0;
      end else if (r_win_cnt != '0) begin
        r_win_cnt <= r_win_cnt - c_WIN_W'(1);
      end else if (r_lfsr[RATE_BITS-1:0] == '0) begin
        r_win_cnt <= c_WINDOW;
      end

      if (w_win_hit) begin
        r_hold_cnt <= c_HOLD_LD;
      end else if ((r_state == c_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
      end

      if (w_win_hit && (r_score != '1)) begin
        r_score <= r_score + SCORE_W'(1);
      end
    end
  end

`ifdef LIGHT_STIM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit && !W && !stop;
      if (r_state == c_ACTIVE) begin
        r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end
`endif

  assign M        = (r_win_cnt != '0);
  assign L        = r_l;
  assign game_rst = (r_state == c_IDLE) || (r_state == c_ARM);
  assign active   = (r_state == c_ACTIVE);
  assign score    = r_score;

endmodule

`default_nettype wire

// File: tb/tb_light_stim_drv.sv
//==============================================================================
// Module      : tb_light_stim_drv
// Description : Randomized self-checking bench for light_stim_drv against a
//               cycle-level behavioural model of the round rules.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_light_stim_drv;

  localparam int WINDOW    = 4;
  localparam int RATE_BITS = 3;
  localparam int WIN_HOLD  = 8;
  localparam int SCORE_W   = 4;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               reset, key, start, stop, W;
  logic               M, L, game_rst, active;
  logic [SCORE_W-1:0] score;
`ifdef LIGHT_STIM_TIMEOUT_EN
  logic               timeout;
`endif

  always #5 clk = ~clk;

  light_stim_drv #(
    .WINDOW(WINDOW), .RATE_BITS(RATE_BITS), .WIN_HOLD(WIN_HOLD),
    .SCORE_W(SCORE_W), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .start(start), .stop(stop), .W(W),
    .M(M), .L(L), .game_rst(game_rst), .score(score), .active(active)
`ifdef LIGHT_STIM_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: round phase, remaining window/hold cycles, score, key history
  typedef enum {MD_IDLE, MD_ARM, MD_PLAY, MD_HOLD} mode_t;
  mode_t       md = MD_IDLE;
  int          win_left = 0;
  int          hold_left = 0;
  int          score_m = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  bit [2:0]    kq = '0;
  bit          l_m = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic model_edge();
    mode_t nm;
    bit    nl;
    if (reset) begin
      md = MD_IDLE; win_left = 0; hold_left = 0; score_m = 0;
      lfsr_m = 16'hACE1; kq = '0; l_m = 1'b0;
      return;
    end
    nm = md;
    if (stop) nm = MD_IDLE;
    else begin
      case (md)
        MD_IDLE: if (start) nm = MD_ARM;
        MD_ARM:  nm = MD_PLAY;
        MD_PLAY: if (W) begin
          nm = MD_HOLD;
          if (score_m < SCORE_MAX) score_m++;
          hold_left = WIN_HOLD;
        end
        MD_HOLD: begin
          hold_left--;
          if (hold_left == 0) nm = MD_ARM;
        end
        default: nm = MD_IDLE;
      endcase
    end
    // key seen 2 edges ago high, 3 edges ago low -> press
    nl = kq[1] && !kq[2] && (md == MD_PLAY) && (nm == MD_PLAY);
    kq = {kq[1:0], key};
    if (md == MD_PLAY && nm == MD_PLAY) begin
      if (win_left > 0) win_left--;
      else if ((lfsr_m % (1 << RATE_BITS)) == 0) win_left = WINDOW;
    end else begin
      win_left = 0;
    end
    if (md == MD_PLAY) lfsr_m = lfsr_next(lfsr_m);
    md  = nm;
    l_m = nl;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("M", M, (win_left > 0));
    check_val("L", L, l_m);
    check_val("game_rst", game_rst, (md == MD_IDLE || md == MD_ARM));
    check_val("active", active, (md == MD_PLAY));
    check_val("score", score, score_m);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, npulse, pcyc, t;
    reset = 1'b1; key = 1'b0; start = 1'b0; stop = 1'b0; W = 1'b0;
    repeat (2) step();
    check_val("rst_game_rst", game_rst, 1);
    check_val("rst_score", score, 0);
    reset = 1'b0;
    repeat (20) step();
    check_val("idle_active", active, 0);

    // Start at cycle 0, key held from cycle 5 for 10 cycles
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    check_val("arm_game_rst", game_rst, 1);
    check_val("arm_active", active, 0);
    step(); c++;
    check_val("play_active", active, 1);
    repeat (3) begin step(); c++; end
    key = 1'b1; npulse = 0; pcyc = -1;
    for (int i = 0; i < 10; i++) begin
      step(); c++;
      if (L) begin npulse++; pcyc = c; end
    end
    key = 1'b0;
    check_val("key_pulses", npulse, 1);
    check_val("key_pulse_cycle", pcyc, 8);

    // stop and W together: abort without scoring
    stop = 1'b1; W = 1'b1;
    step();
    stop = 1'b0; W = 1'b0;
    check_val("stopw_score", score, 0);
    check_val("stopw_game_rst", game_rst, 1);
    check_val("stopw_active", active, 0);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 16) == 0;
      stop  = ($urandom % 64) == 0;
      W     = ($urandom % 24) == 0;
      if (($urandom % 6) == 0) key = ~key;
      step();
    end
    start = 1'b0; stop = 1'b0; W = 1'b0; key = 1'b0;

    // Drive enough wins to saturate, checking the hold/arm gap length
    start = 1'b1;
    step();
    start = 1'b0;
    for (int w = 0; w < 17; w++) begin
      t = 0;
      while (!active && t < 40) begin step(); t++; end
      if (!active) check_val("active_wait", active, 1);
      if (w > 0) check_val("hold_len", t, WIN_HOLD + 1);
      W = 1'b1;
      step();
      W = 1'b0;
      check_val("win_active_drop", active, 0);
    end
    check_val("score_sat", score, 15);
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
